// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer sequencer.
package rt_pkg;

  localparam int unsigned LFSR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_GO   = 3'd2,
    ST_STOP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a bit mask over q[15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;

endpackage

// File: rtl/lfsr_16.sv
// Free-running 16-bit Fibonacci LFSR; loads seed while in reset.
module lfsr_16
  import rt_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) q <= seed;
    else          q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Sequences random pre-LED delay, counter start/stop and result latching
// for one reaction-timer attempt.
module reaction_timer_ctrl
  import rt_pkg::*;
#(
  parameter int unsigned       BIT_SZ    = 16,
  parameter int unsigned       MIN_DELAY = 1000,
  parameter int unsigned       RAND_BITS = 11,
  parameter int unsigned       MAX_COUNT = 9999,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tick_ms,
  input  logic              trigger,
  input  logic              react,
  input  logic [BIT_SZ-1:0] count_in,
  output logic              cnt_start,
  output logic              cnt_stop,
  output logic              led,
  output logic              busy,
  output logic [BIT_SZ-1:0] result,
  output logic              result_valid,
  output logic              timeout,
  output logic              false_start
);

  if (MIN_DELAY + (1 << RAND_BITS) - 1 > (1 << BIT_SZ) - 1) begin : g_bad_delay
    $error("MIN_DELAY + 2^RAND_BITS - 1 does not fit in BIT_SZ");
  end
  if (RAND_BITS < 1 || RAND_BITS > LFSR_W) begin : g_bad_rand
    $error("RAND_BITS must be 1..16");
  end

  state_t              state;
  logic [BIT_SZ-1:0]   delay_cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic                stop_cond;
  logic                delay_zero;
  logic                unused_lfsr_bits;

  lfsr_16 u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .q       (lfsr)
  );

  // Only the low RAND_BITS feed the delay; the rest just keep the sequence long.
  assign unused_lfsr_bits = ^lfsr;

  assign stop_cond  = react || (count_in >= BIT_SZ'(MAX_COUNT));
  assign delay_zero = (delay_cnt == '0);

  // Counter is held stopped everywhere except a running GO; start only on ARM->GO.
  always_comb begin
    cnt_start = 1'b0;
    cnt_stop  = 1'b1;
    case (state)
      ST_ARM: if (tick_ms && delay_zero && !react) begin
        cnt_start = 1'b1;
        cnt_stop  = 1'b0;
      end
      ST_GO:  cnt_stop = stop_cond;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      delay_cnt    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      false_start  <= 1'b0;
      led          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (trigger) begin
          state        <= ST_ARM;
          busy         <= 1'b1;
          delay_cnt    <= BIT_SZ'(MIN_DELAY) + BIT_SZ'(lfsr[RAND_BITS-1:0]);
          result_valid <= 1'b0;
          timeout      <= 1'b0;
          false_start  <= 1'b0;
        end
        ST_ARM: begin
          if (react) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            false_start  <= 1'b1;
            result_valid <= 1'b1;
          end else if (tick_ms) begin
            if (!delay_zero) begin
              delay_cnt <= delay_cnt - BIT_SZ'(1);
            end else begin
              state <= ST_GO;
              led   <= 1'b1;
            end
          end
        end
        ST_GO: if (stop_cond) begin
          state <= ST_STOP;
          led   <= 1'b0;
          if (!react) timeout <= 1'b1;
        end
        ST_STOP: begin
          state        <= ST_DONE;
          busy         <= 1'b0;
          result       <= count_in;
          result_valid <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl.
module tb_reaction_timer_ctrl;

  localparam int unsigned BIT_SZ    = 16;
  localparam int unsigned MIN_DELAY = 4;
  localparam int unsigned RAND_BITS = 2;
  localparam int unsigned MAX_COUNT = 40;

  logic              clock;
  logic              reset_n;
  logic              tick_ms;
  logic              trigger;
  logic              react;
  logic [BIT_SZ-1:0] count_in;
  logic              cnt_start;
  logic              cnt_stop;
  logic              led;
  logic              busy;
  logic [BIT_SZ-1:0] result;
  logic              result_valid;
  logic              timeout;
  logic              false_start;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;

  reaction_timer_ctrl #(
    .BIT_SZ    (BIT_SZ),
    .MIN_DELAY (MIN_DELAY),
    .RAND_BITS (RAND_BITS),
    .MAX_COUNT (MAX_COUNT),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tick_ms      (tick_ms),
    .trigger      (trigger),
    .react        (react),
    .count_in     (count_in),
    .cnt_start    (cnt_start),
    .cnt_stop     (cnt_stop),
    .led          (led),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .timeout      (timeout),
    .false_start  (false_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR: taps 16,14,13,11, shifting towards the MSB.
  always @(posedge clock) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    trigger = 1'b0;
    react   = 1'b0;
    tick_ms = 1'b0;
  endtask

  // Trigger an attempt and tick through ARM until the counter is started.
  task automatic run_to_go(input bit trig_mid);
    int  ticks;
    int  exp_d;
    bit  seen;
    trigger = 1'b1;
    exp_d   = int'(MIN_DELAY) + int'(m_lfsr[1:0]);
    step();
    chk("arm_busy", busy, 1);
    chk("arm_rv_clr", result_valid, 0);
    chk("arm_to_clr", timeout, 0);
    chk("arm_fs_clr", false_start, 0);
    chk("arm_led", led, 0);
    ticks = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick_ms = i[0];
      if (trig_mid && i == 5) trigger = 1'b1;
      #1;
      if (tick_ms) ticks++;
      if (cnt_start) begin
        seen = 1'b1;
        chk("start_no_stop", cnt_stop, 0);
      end
      step();
    end
    chk("start_seen", seen, 1);
    chk("delay_ticks", ticks, exp_d + 1);
    count_in = '0;
    chk("go_led", led, 1);
    chk("go_busy", busy, 1);
  endtask

  task automatic count_to(input int target);
    for (int k = 0; k < 1000 && int'(count_in) < target; k++) begin
      step();
      count_in = count_in + 16'd1;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    tick_ms  = 1'b0;
    trigger  = 1'b0;
    react    = 1'b0;
    count_in = '0;
    step();
    step();
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_cnt_stop", cnt_stop, 1);
    chk("rst_cnt_start", cnt_start, 0);
    reset_n = 1'b1;
    step();
    step();

    // Normal attempt, react at count 37
    run_to_go(1'b0);
    count_to(20);
    #1;
    chk("go_running", cnt_stop, 0);
    count_to(37);
    react = 1'b1;
    #1;
    chk("react_stop", cnt_stop, 1);
    chk("react_no_start", cnt_start, 0);
    step();
    chk("stop_led", led, 0);
    chk("stop_rv", result_valid, 0);
    chk("stop_busy", busy, 1);
    step();
    chk("done_rv", result_valid, 1);
    chk("done_result", result, 37);
    chk("done_to", timeout, 0);
    chk("done_fs", false_start, 0);
    chk("done_busy", busy, 0);

    // False start: react (with a tick) while armed
    trigger = 1'b1;
    step();
    chk("fs_rv_clr", result_valid, 0);
    tick_ms = 1'b1;
    step();
    react   = 1'b1;
    tick_ms = 1'b1;
    #1;
    chk("fs_no_start", cnt_start, 0);
    step();
    chk("fs_flag", false_start, 1);
    chk("fs_rv", result_valid, 1);
    chk("fs_result_kept", result, 37);
    chk("fs_led", led, 0);
    chk("fs_busy", busy, 0);
    react = 1'b1;
    step();
    chk("done_react_ignored", result_valid, 1);

    // React and limit on the same cycle
    run_to_go(1'b0);
    count_to(int'(MAX_COUNT));
    react = 1'b1;
    #1;
    chk("tie_stop", cnt_stop, 1);
    step();
    step();
    chk("tie_to", timeout, 0);
    chk("tie_result", result, MAX_COUNT);
    chk("tie_rv", result_valid, 1);

    // Timeout, with stray triggers in ARM and GO
    run_to_go(1'b1);
    count_to(int'(MAX_COUNT) - 1);
    trigger = 1'b1;
    #1;
    chk("pre_limit_run", cnt_stop, 0);
    step();
    chk("go_trig_led", led, 1);
    chk("go_trig_busy", busy, 1);
    count_in = 16'(MAX_COUNT);
    #1;
    chk("limit_stop", cnt_stop, 1);
    step();
    step();
    chk("to_flag", timeout, 1);
    chk("to_result", result, MAX_COUNT);
    chk("to_rv", result_valid, 1);
    chk("to_fs", false_start, 0);

    // Reset while counter is running
    run_to_go(1'b0);
    count_to(10);
    reset_n = 1'b0;
    step();
    #1;
    chk("mid_rst_stop", cnt_stop, 1);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_to", timeout, 0);
    chk("mid_rst_fs", false_start, 0);
    reset_n = 1'b1;
    step();
    chk("idle_stop", cnt_stop, 1);

    // Fresh attempt after reset still sequences from the seed
    run_to_go(1'b0);
    count_to(5);
    react = 1'b1;
    step();
    step();
    chk("post_rst_result", result, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
